// File: rtl/seg7_pkg.sv
// Shared glyph constants and segment bit-order definitions for the 7-segment scan driver.
package seg7_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam int unsigned SGM_W     = 8;
    localparam int unsigned NIBBLE_W  = 4;

    // Bit positions inside the 7-bit glyph {a,b,c,d,e,f,g}
    localparam int unsigned SEG_A_BIT = 6;
    localparam int unsigned SEG_B_BIT = 5;
    localparam int unsigned SEG_C_BIT = 4;
    localparam int unsigned SEG_D_BIT = 3;
    localparam int unsigned SEG_E_BIT = 2;
    localparam int unsigned SEG_F_BIT = 1;
    localparam int unsigned SEG_G_BIT = 0;

    typedef logic [SEG_W-1:0] seg_t;

    // Pin payload {a,b,c,d,e,f,g,dp}, all active-low
    typedef struct packed {
        seg_t seg;
        logic dp;
    } sgm_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam sgm_t SGM_OFF   = '{seg: SEG_BLANK, dp: 1'b1};

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Data/display bundle between the counter datapath (master) and the scan driver (slave).
interface seg7_scan_driver_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic                      en;
    logic                      lzb;
    logic [4*N_DIGITS-1:0]     data_i;
    logic [N_DIGITS-1:0]       dp_i;
    logic [N_DIGITS-1:0]       an_o;
    logic [7:0]                sgm_o;
    logic                      frame_o;

    modport master (
        output en, lzb, data_i, dp_i,
        input  an_o, sgm_o, frame_o
    );

    modport slave (
        input  en, lzb, data_i, dp_i,
        output an_o, sgm_o, frame_o
    );
endinterface

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph decoder; blank overrides the decoded pattern.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    input  logic                hex_mode,
    input  logic                blank,
    output seg_t                seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (nibble)
            4'h0:    seg_c = SEG_0;
            4'h1:    seg_c = SEG_1;
            4'h2:    seg_c = SEG_2;
            4'h3:    seg_c = SEG_3;
            4'h4:    seg_c = SEG_4;
            4'h5:    seg_c = SEG_5;
            4'h6:    seg_c = SEG_6;
            4'h7:    seg_c = SEG_7;
            4'h8:    seg_c = SEG_8;
            4'h9:    seg_c = SEG_9;
            4'hA:    seg_c = hex_mode ? SEG_A : SEG_BLANK;
            4'hB:    seg_c = hex_mode ? SEG_B : SEG_BLANK;
            4'hC:    seg_c = hex_mode ? SEG_C : SEG_BLANK;
            4'hD:    seg_c = hex_mode ? SEG_D : SEG_BLANK;
            4'hE:    seg_c = hex_mode ? SEG_E : SEG_BLANK;
            4'hF:    seg_c = hex_mode ? SEG_F : SEG_BLANK;
            default: seg_c = SEG_BLANK;
        endcase
        if (blank) seg_c = SEG_BLANK;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with per-frame snapshot,
// leading-zero blanking and a dead window at the start of every digit slot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYCLES = 2,
    parameter int unsigned HEX_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_driver_if.slave     bus
);

    localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned DATA_W = NIBBLE_W * N_DIGITS;
    localparam logic        HEX_ON = (HEX_MODE != 0);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   snap_d_q, snap_d_d;
    logic [N_DIGITS-1:0] snap_dp_q, snap_dp_d;
    logic                lzb_q, lzb_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    sgm_t                sgm_q, sgm_d;
    logic                frame_q, frame_d;

    logic                wrap_c, last_c, frame_edge_c, lit_c;
    logic [NIBBLE_W-1:0] nib_c;
    logic                dp_sel_c, lead_c, zero_run_c, blank_c;
    seg_t                glyph_c;

    // Next-state for slot counter, digit index and frame snapshot
    always_comb begin
        wrap_c       = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        last_c       = (idx_q == IDX_W'(N_DIGITS - 1));
        frame_edge_c = bus.en & wrap_c & last_c;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_d_d     = snap_d_q;
        snap_dp_d    = snap_dp_q;
        lzb_d        = lzb_q;
        if (bus.en) begin
            cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
            if (wrap_c) idx_d = last_c ? '0 : idx_q + IDX_W'(1);
        end
        if (frame_edge_c) begin
            snap_d_d  = bus.data_i;
            snap_dp_d = bus.dp_i;
            lzb_d     = bus.lzb;
        end
    end

    // Select current digit; a digit is a leading zero if it and every digit above it is 0
    always_comb begin
        nib_c      = '0;
        dp_sel_c   = 1'b0;
        lead_c     = 1'b0;
        zero_run_c = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run_c = zero_run_c & (snap_d_q[NIBBLE_W*k +: NIBBLE_W] == '0);
            if (idx_q == IDX_W'(k)) begin
                nib_c    = snap_d_q[NIBBLE_W*k +: NIBBLE_W];
                dp_sel_c = snap_dp_q[k];
                lead_c   = zero_run_c & (k != 0);
            end
        end
        blank_c = lzb_q & lead_c;
    end

    seg7_glyph u_glyph (
        .nibble   (nib_c),
        .hex_mode (HEX_ON),
        .blank    (blank_c),
        .seg_c    (glyph_c)
    );

    // Pin values for the next cycle: dark during the dead window or while disabled
    always_comb begin
        lit_c   = bus.en & (cnt_q >= CNT_W'(DEAD_CYCLES));
        an_d    = '1;
        sgm_d   = SGM_OFF;
        frame_d = frame_edge_c;
        if (lit_c) begin
            an_d      = ~(N_DIGITS'(1) << idx_q);
            sgm_d.seg = glyph_c;
            sgm_d.dp  = ~dp_sel_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_d_q  <= '0;
            snap_dp_q <= '0;
            lzb_q     <= 1'b0;
            an_q      <= '1;
            sgm_q     <= SGM_OFF;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_d_q  <= snap_d_d;
            snap_dp_q <= snap_dp_d;
            lzb_q     <= lzb_d;
            an_q      <= an_d;
            sgm_q     <= sgm_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.an_o    = an_q;
    assign bus.sgm_o   = sgm_q;
    assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: one hex-mode and one decimal-mode instance share stimulus.
module tb_seg7_scan_driver;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   base  = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_scan_driver_if #(.N_DIGITS(4)) b1 ();
    seg7_scan_driver_if #(.N_DIGITS(4)) b0 ();

    assign b0.en     = b1.en;
    assign b0.lzb    = b1.lzb;
    assign b0.data_i = b1.data_i;
    assign b0.dp_i   = b1.dp_i;

    seg7_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .HEX_MODE(1)) dut_hex (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    seg7_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .HEX_MODE(0)) dut_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] sgm;
        logic [7:0] sgm0;
        logic       frame;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    task automatic pushx(input int e, input logic [3:0] an, input logic [7:0] sgm,
                         input logic [7:0] sgm0, input logic fr, input string nm);
        exp_t x;
        x.cyc   = base + e;
        x.an    = an;
        x.sgm   = sgm;
        x.sgm0  = sgm0;
        x.frame = fr;
        x.name  = nm;
        q.push_back(x);
    endtask

    task automatic push(input int e, input logic [3:0] an, input logic [7:0] sgm,
                        input logic fr, input string nm);
        pushx(e, an, sgm, sgm, fr, nm);
    endtask

    task automatic wait_edge(input int e);
        while (cyc < base + e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare outputs at the falling edge whenever an expectation is due
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: sample missed, now cycle %0d, due %0d", q[0].name, cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            cur = q.pop_front();
            n_cmp++;
            if (b1.an_o !== cur.an || b1.sgm_o !== cur.sgm || b1.frame_o !== cur.frame) begin
                n_bad++;
                $display("FAIL %s: an=%b sgm=%b frame=%b, expected an=%b sgm=%b frame=%b",
                         cur.name, b1.an_o, b1.sgm_o, b1.frame_o, cur.an, cur.sgm, cur.frame);
            end
            n_cmp++;
            if (b0.an_o !== cur.an || b0.sgm_o !== cur.sgm0 || b0.frame_o !== cur.frame) begin
                n_bad++;
                $display("FAIL %s/dec: an=%b sgm=%b frame=%b, expected an=%b sgm=%b frame=%b",
                         cur.name, b0.an_o, b0.sgm_o, b0.frame_o, cur.an, cur.sgm0, cur.frame);
            end
        end
    end

    initial begin
        b1.en     = 1'b1;
        b1.lzb    = 1'b0;
        b1.data_i = 16'h1234;
        b1.dp_i   = 4'b0000;
        base      = 0;
        push(2, 4'b1111, 8'hFF, 1'b0, "reset_hold");
        wait_edge(3);
        rst_n = 1'b1;
        base  = cyc;

        // First frame shows the all-zero reset snapshot, then 1234
        push(1,  4'b1111, 8'hFF, 1'b0, "first_dead");
        push(2,  4'b1110, 8'h03, 1'b0, "first_d0_zero");
        push(16, 4'b0111, 8'h03, 1'b1, "first_frame");
        push(17, 4'b1111, 8'hFF, 1'b0, "f1_dead");
        push(18, 4'b1110, 8'h99, 1'b0, "f1_d0_4_a");
        push(20, 4'b1110, 8'h99, 1'b0, "f1_d0_4_c");
        push(21, 4'b1111, 8'hFF, 1'b0, "f1_d1_dead");
        push(22, 4'b1101, 8'h0D, 1'b0, "f1_d1_3");
        push(26, 4'b1011, 8'h25, 1'b0, "f1_d2_2");
        push(30, 4'b0111, 8'h9F, 1'b0, "f1_d3_1");
        push(32, 4'b0111, 8'h9F, 1'b1, "f1_frame");
        // Leading-zero blanking on 0050 with dp on digit 2
        push(34, 4'b1110, 8'h03, 1'b0, "lzb_d0");
        push(38, 4'b1101, 8'h49, 1'b0, "lzb_d1");
        push(42, 4'b1011, 8'hFE, 1'b0, "lzb_d2_dp");
        push(46, 4'b0111, 8'hFF, 1'b0, "lzb_d3");
        push(48, 4'b0111, 8'hFF, 1'b1, "lzb_frame");
        // Hex codes ABCF
        pushx(50, 4'b1110, 8'h71, 8'hFF, 1'b0, "hex_d0_F");
        pushx(54, 4'b1101, 8'h63, 8'hFF, 1'b0, "hex_d1_C");
        pushx(58, 4'b1011, 8'hC1, 8'hFF, 1'b0, "hex_d2_b");
        pushx(62, 4'b0111, 8'h11, 8'hFF, 1'b0, "hex_d3_A");
        pushx(64, 4'b0111, 8'h11, 8'hFF, 1'b1, "hex_frame");
        // Mid-frame data change must not tear the display
        push(66, 4'b1110, 8'h9F, 1'b0, "snap_d0_1");
        push(74, 4'b1011, 8'h9F, 1'b0, "snap_d2_still1");
        push(78, 4'b0111, 8'h9F, 1'b0, "snap_d3_still1");
        push(80, 4'b0111, 8'h9F, 1'b1, "snap_frame");
        push(82, 4'b1110, 8'h25, 1'b0, "snap_d0_2");
        push(88, 4'b1101, 8'h25, 1'b0, "snap_no_pulse");
        push(94, 4'b0111, 8'h25, 1'b0, "snap_d3_2");
        push(96, 4'b0111, 8'h25, 1'b1, "snap_frame2");
        // Freeze at cnt=2, idx=2 for 10 cycles
        push(106, 4'b1011, 8'h25, 1'b0, "pre_freeze");
        push(107, 4'b1111, 8'hFF, 1'b0, "freeze_blank");
        push(112, 4'b1111, 8'hFF, 1'b0, "freeze_no_frame");
        push(116, 4'b1111, 8'hFF, 1'b0, "freeze_last");
        push(117, 4'b1011, 8'h25, 1'b0, "resume_cnt2");
        push(118, 4'b1011, 8'h25, 1'b0, "resume_cnt3");
        push(119, 4'b1111, 8'hFF, 1'b0, "resume_dead_d3");
        push(120, 4'b0111, 8'h25, 1'b0, "resume_d3");
        push(122, 4'b0111, 8'h25, 1'b1, "resume_frame");
        push(123, 4'b1111, 8'hFF, 1'b0, "resume_dead_d0");
        push(124, 4'b1110, 8'h25, 1'b0, "pre_async");
        // Asynchronous reset between edges
        push(125, 4'b1111, 8'hFF, 1'b0, "async_reset");
        push(126, 4'b1111, 8'hFF, 1'b0, "async_hold");

        wait_edge(17);
        b1.data_i = 16'h0050;
        b1.lzb    = 1'b1;
        b1.dp_i   = 4'b0100;
        wait_edge(33);
        b1.data_i = 16'hABCF;
        b1.lzb    = 1'b0;
        b1.dp_i   = 4'b0000;
        wait_edge(49);
        b1.data_i = 16'h1111;
        wait_edge(69);
        b1.data_i = 16'h2222;
        wait_edge(106);
        b1.en = 1'b0;
        wait_edge(116);
        b1.en = 1'b1;
        wait_edge(125);
        rst_n = 1'b0;
        wait_edge(128);
        rst_n = 1'b1;
        base  = cyc;

        // After release the scan restarts at digit 0 with a zero snapshot
        push(1,  4'b1111, 8'hFF, 1'b0, "rel_dead");
        push(2,  4'b1110, 8'h03, 1'b0, "rel_d0_zero");
        push(8,  4'b1101, 8'h03, 1'b0, "rel_d1_zero");
        push(16, 4'b0111, 8'h03, 1'b1, "rel_frame");
        push(18, 4'b1110, 8'h25, 1'b0, "rel_d0_2");

        wait_edge(20);
        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations pending, expected 0", q.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
